// File: rtl/judge_pkg.sv
// Shared types, constants and helpers for the sequence_judge game core.
package judge_pkg;

  typedef enum logic [2:0] {
    GEN,
    SHOW,
    INPUT,
    WIN,
    LOSE
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int unsigned BTN_W = 4;
  localparam int unsigned IDX_W = 2;

  // Galois right-shift step of the 16-bit LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

  // Element recorded for a GEN cycle: low bits of the post-shift value.
  function automatic logic [IDX_W-1:0] lfsr_elem(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = lfsr_step(cur);
    return nxt[IDX_W-1:0];
  endfunction

  function automatic logic [BTN_W-1:0] onehot(input logic [IDX_W-1:0] e);
    return BTN_W'(1) << e;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Single 16-bit Galois LFSR; loads seed on reset and shifts when step_en is high.
module lfsr16
  import judge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        step_en,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= seed;
    end else if (step_en) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/sequence_judge.sv
// Game core: generates a pseudo-random sequence, shows it on the LEDs, then judges presses.
// Optional input idle timeout is enabled by defining SEQUENCE_JUDGE_TIMEOUT_EN.
module sequence_judge
  import judge_pkg::*;
#(
  parameter int unsigned SEQ_LEN     = 8,
  parameter int unsigned DISP_CYC    = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             display_phase,
  input  logic [BTN_W-1:0] btn_pulse,
  output logic [BTN_W-1:0] led,
  output logic [4:0]       score,
  output logic             win,
  output logic             lose
);

  localparam int unsigned SI_W = $clog2(SEQ_LEN);
  localparam int unsigned DC_W = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;
  localparam logic [SI_W-1:0] LAST_IDX  = SI_W'(SEQ_LEN - 1);
  localparam logic [DC_W-1:0] LAST_DISP = DC_W'(DISP_CYC - 1);

  if (SEQ_LEN < 2 || SEQ_LEN > 16 || SEED == 16'h0 || DISP_CYC == 0 || TIMEOUT_CYC == 0)
  begin : g_param_check
    $error("sequence_judge: illegal parameter value");
  end

  state_t state, state_d;

  logic [SI_W-1:0]  gen_cnt, gen_d;
  logic [SI_W-1:0]  show_idx, show_d;
  logic [SI_W-1:0]  step, step_d;
  logic [DC_W-1:0]  disp_cnt, disp_d;
  logic [4:0]       score_d;
  logic [BTN_W-1:0] led_d;
  logic [IDX_W-1:0] expect_elem;
  logic [IDX_W-1:0] seq [SEQ_LEN];
  logic [15:0]      lfsr_value;

`ifdef SEQUENCE_JUDGE_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDLE_W-1:0] LAST_IDLE = IDLE_W'(TIMEOUT_CYC - 1);
  logic [IDLE_W-1:0] idle_cnt, idle_d;
`endif

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .seed    (SEED),
    .step_en (state == GEN),
    .value   (lfsr_value)
  );

  // Sequence store: one element captured per GEN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SEQ_LEN); i++) begin
        seq[i] <= '0;
      end
    end else if (state == GEN) begin
      seq[gen_cnt] <= lfsr_elem(lfsr_value);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GEN;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_d     = state;
    gen_d       = gen_cnt;
    show_d      = show_idx;
    disp_d      = disp_cnt;
    step_d      = step;
    score_d     = score;
    expect_elem = seq[step];
`ifdef SEQUENCE_JUDGE_TIMEOUT_EN
    idle_d      = idle_cnt;
`endif

    case (state)
      GEN: begin
        gen_d = gen_cnt + 1'b1;
        if (gen_cnt == LAST_IDX) begin
          state_d = display_phase ? SHOW : INPUT;
        end
      end

      SHOW: begin
        if (!display_phase) begin
          state_d = INPUT;
        end else if (disp_cnt == LAST_DISP) begin
          disp_d = '0;
          show_d = (show_idx == LAST_IDX) ? '0 : show_idx + 1'b1;
        end else begin
          disp_d = disp_cnt + 1'b1;
        end
      end

      INPUT: begin
        // A press always wins over a timeout landing in the same cycle.
        if (btn_pulse != '0) begin
          if (btn_pulse == onehot(expect_elem)) begin
            score_d = score + 5'd1;
            step_d  = step + 1'b1;
`ifdef SEQUENCE_JUDGE_TIMEOUT_EN
            idle_d  = '0;
`endif
            if (step == LAST_IDX) begin
              state_d = WIN;
            end
          end else begin
            state_d = LOSE;
          end
        end
`ifdef SEQUENCE_JUDGE_TIMEOUT_EN
        else if (idle_cnt == LAST_IDLE) begin
          state_d = LOSE;
        end else begin
          idle_d = idle_cnt + 1'b1;
        end
`endif
      end

      default: begin
      end
    endcase

    led_d = (state_d == SHOW) ? onehot(seq[show_d]) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gen_cnt  <= '0;
      show_idx <= '0;
      disp_cnt <= '0;
      step     <= '0;
      score    <= '0;
      led      <= '0;
      win      <= 1'b0;
      lose     <= 1'b0;
`ifdef SEQUENCE_JUDGE_TIMEOUT_EN
      idle_cnt <= '0;
`endif
    end else begin
      gen_cnt  <= gen_d;
      show_idx <= show_d;
      disp_cnt <= disp_d;
      step     <= step_d;
      score    <= score_d;
      led      <= led_d;
      win      <= (state_d == WIN);
      lose     <= (state_d == LOSE);
`ifdef SEQUENCE_JUDGE_TIMEOUT_EN
      idle_cnt <= idle_d;
`endif
    end
  end

endmodule

// File: tb/tb_sequence_judge.sv
// Self-checking bench for sequence_judge against a rule-level reference model.
module tb_sequence_judge;

  localparam int unsigned SEQ_LEN     = 8;
  localparam int unsigned DISP_CYC    = 4;
  localparam int unsigned TIMEOUT_CYC = 10;
  localparam logic [15:0] SEED        = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       display_phase = 1'b0;
  logic [3:0] btn_pulse = 4'b0;
  logic [3:0] led;
  logic [4:0] score;
  logic       win;
  logic       lose;

  int n_tests = 0;
  int n_fail  = 0;

  int mseq [SEQ_LEN];
  int spec_seq [8] = '{0, 0, 0, 2, 3, 3, 1, 0};
  int m_score;
  int m_step;
  bit m_win;
  bit m_lose;

  sequence_judge #(
    .SEQ_LEN     (SEQ_LEN),
    .DISP_CYC    (DISP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SEED        (SEED)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .display_phase (display_phase),
    .btn_pulse     (btn_pulse),
    .led           (led),
    .score         (score),
    .win           (win),
    .lose          (lose)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int e);
    return 4'(1 << e);
  endfunction

  // Sequence derived directly from the LFSR rule with plain arithmetic.
  function automatic void build_model();
    int l;
    l = int'(SEED);
    for (int k = 0; k < int'(SEQ_LEN); k++) begin
      if (l % 2 == 1) l = (l / 2) ^ 'hB400;
      else            l = l / 2;
      mseq[k] = l % 4;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_game(input string tag);
    check({tag, ".score"}, 8'(score), 8'(m_score));
    check({tag, ".win"},   8'(win),   8'(m_win));
    check({tag, ".lose"},  8'(lose),  8'(m_lose));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_pulse = 4'b0;
    m_score = 0; m_step = 0; m_win = 1'b0; m_lose = 1'b0;
    tick();
    check("reset.led", 8'(led), 8'h0);
    check_game("reset");
    tick();
    rst = 1'b0;
  endtask

  // Runs the GEN cycles with random (ignored) presses; ends in SHOW or INPUT.
  task automatic run_gen(input bit dp);
    display_phase = dp;
    for (int i = 0; i < int'(SEQ_LEN) - 1; i++) begin
      btn_pulse = 4'($urandom_range(0, 15));
      tick();
      check("gen.led", 8'(led), 8'h0);
      check("gen.score", 8'(score), 8'h0);
    end
    btn_pulse = 4'($urandom_range(0, 15));
    tick();
    btn_pulse = 4'b0;
  endtask

  task automatic show_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      check("show.led", 8'(led), 8'(oh(mseq[(c / int'(DISP_CYC)) % int'(SEQ_LEN)])));
      check("show.score", 8'(score), 8'h0);
      btn_pulse = 4'($urandom_range(0, 15));
      tick();
    end
    btn_pulse = 4'b0;
  endtask

  task automatic drop_phase();
    display_phase = 1'b0;
    btn_pulse = 4'b0;
    tick();
    check("drop.led", 8'(led), 8'h0);
  endtask

  task automatic press(input logic [3:0] b);
    if (!m_win && !m_lose && b != 4'b0) begin
      if (b == oh(mseq[m_step])) begin
        m_score++;
        m_step++;
        if (m_step == int'(SEQ_LEN)) m_win = 1'b1;
      end else begin
        m_lose = 1'b1;
      end
    end
    btn_pulse = b;
    tick();
    btn_pulse = 4'b0;
    check("input.led", 8'(led), 8'h0);
    check_game("press");
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) begin
      display_phase = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic wrong_press();
    logic [3:0] b;
    do b = 4'($urandom_range(1, 15)); while (b == oh(mseq[m_step]));
    press(b);
  endtask

  initial begin
    int k;
    bit dp;
    build_model();

    // Full game: show with wrap, then correct entry to a win.
    do_reset();
    run_gen(1'b1);
    for (int c = 0; c < int'(SEQ_LEN * DISP_CYC + DISP_CYC); c++) begin
      check("spec_show.led", 8'(led), 8'(oh(spec_seq[(c / int'(DISP_CYC)) % 8])));
      check("spec_show.score", 8'(score), 8'h0);
      btn_pulse = 4'($urandom_range(0, 15));
      tick();
    end
    drop_phase();
    for (int i = 0; i < int'(SEQ_LEN); i++) begin
      press(oh(spec_seq[i]));
      gap();
    end
    check("win.flag", 8'(win), 8'h1);
    repeat (3) press(4'($urandom_range(1, 15)));

    // Wrong fourth press, then a correct-looking press is ignored.
    do_reset();
    run_gen(1'b0);
    check("direct_input.led", 8'(led), 8'h0);
    for (int i = 0; i < 3; i++) press(oh(mseq[i]));
    press(4'b0010);
    check("lose.score", 8'(score), 8'd3);
    press(oh(mseq[3]));

    // Multi-bit first press loses.
    do_reset();
    run_gen(1'b1);
    show_cycles(7);
    drop_phase();
    press(4'b0011);
    check("multi.lose", 8'(lose), 8'h1);

    // Randomized games.
    repeat (12) begin
      do_reset();
      dp = 1'($urandom_range(0, 1));
      run_gen(dp);
      if (dp) begin
        show_cycles(int'($urandom_range(1, 40)));
        drop_phase();
      end
      k = int'($urandom_range(0, SEQ_LEN));
      for (int i = 0; i < k; i++) begin
        press(oh(mseq[m_step]));
        gap();
      end
      if (k < int'(SEQ_LEN) && $urandom_range(0, 1) == 1) wrong_press();
      repeat (2) press(4'($urandom_range(0, 15)));
    end

`ifdef SEQUENCE_JUDGE_TIMEOUT_EN
    // Idle timeout, then reset regenerates the same sequence.
    do_reset();
    run_gen(1'b0);
    repeat (TIMEOUT_CYC - 1) begin
      tick();
      check("timeout.pending", 8'(lose), 8'h0);
    end
    tick();
    check("timeout.lose", 8'(lose), 8'h1);
    do_reset();
    run_gen(1'b1);
    show_cycles(int'(SEQ_LEN * DISP_CYC));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
